// File: rtl/xeng_pkg.sv
// Shared sizing helpers and tag layout for the X-engine accumulator unloader.
// Tag layout, LSB first: last, ant, tap, win.
package xeng_pkg;

    localparam int TAG_LAST_POS = 0;
    localparam int TAG_ANT_LSB  = 1;

    function automatic int log2ceil(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) <= v) r = i;
        end
        return r;
    endfunction

    function automatic int acc_width(input int bitwidth, input int p_bits, input int sacc_bits);
        return 4 * 2 * ((2 * bitwidth + 1) + p_bits + sacc_bits);
    endfunction

    function automatic int n_taps(input int n_ants);
        return n_ants / 2 + 1;
    endfunction

    function automatic int tag_width(input int ant_bits, input int tap_bits, input int win_bits);
        return 1 + ant_bits + tap_bits + win_bits;
    endfunction

endpackage

// File: rtl/xeng_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output stage.
// Capacity is 2^DEPTH_BITS RAM entries plus the output register.
module xeng_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_BITS:0]   count_reg;
    logic [WIDTH-1:0]      data_reg;
    logic                  valid_reg;
    logic                  pop, push, load, mem_rd, mem_wr, bypass;

    // Full looks only at the RAM, so a same-cycle pop never frees room for a write.
    always_comb begin
        full   = (count_reg == DEPTH_CNT);
        pop    = valid_reg && rd_ready;
        push   = wr_en && !full;
        load   = !valid_reg || pop;
        mem_rd = load && (count_reg != '0);
        bypass = load && (count_reg == '0) && push;
        mem_wr = push && !bypass;
    end

    always_ff @(posedge clk) begin
        if (mem_wr) mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            if (mem_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (mem_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({mem_wr, mem_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
            if (mem_rd) begin
                data_reg  <= mem[rd_ptr_reg];
                valid_reg <= 1'b1;
            end else if (bypass) begin
                data_reg  <= wr_data;
                valid_reg <= 1'b1;
            end else if (load) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign rd_data = data_reg;
    assign empty   = !valid_reg;

endmodule

// File: rtl/xeng_acc_unloader.sv
// Receives accumulated words from the end of the tap chain, tags them with
// antenna/tap/window indices and streams them out through a small FIFO.
module xeng_acc_unloader
    import xeng_pkg::*;
#(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int P_FACTOR_BITS       = 0,
    parameter int BITWIDTH            = 4,
    parameter int N_ANTS              = 8,
    parameter int FIFO_DEPTH_BITS     = 5,
    parameter int WIN_CTR_BITS        = 16,
    localparam int ACC_WIDTH = acc_width(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS),
    localparam int N_TAPS    = n_taps(N_ANTS),
    localparam int ANT_BITS  = log2(N_ANTS),
    localparam int TAP_BITS  = log2ceil(N_TAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync_in,
    input  logic [ACC_WIDTH-1:0]    acc_in,
    input  logic                    valid_in,
    output logic [ACC_WIDTH-1:0]    out_data,
    output logic [ANT_BITS-1:0]     out_ant,
    output logic [TAP_BITS-1:0]     out_tap,
    output logic [WIN_CTR_BITS-1:0] out_win,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow,
    output logic                    sync_err
);
    localparam int TAG_WIDTH = tag_width(ANT_BITS, TAP_BITS, WIN_CTR_BITS);
    localparam int TAP_LSB   = TAG_ANT_LSB + ANT_BITS;
    localparam int WIN_LSB   = TAP_LSB + TAP_BITS;
    localparam logic [ANT_BITS-1:0] ANT_MAX = ANT_BITS'(N_ANTS - 1);
    localparam logic [TAP_BITS-1:0] TAP_MAX = TAP_BITS'(N_TAPS - 1);

    logic                    sync_reg, valid_reg;
    logic [ACC_WIDTH-1:0]    acc_reg;
    logic [ANT_BITS-1:0]     ant_reg, ant_cur, ant_next;
    logic [TAP_BITS-1:0]     tap_reg, tap_cur, tap_next;
    logic [WIN_CTR_BITS-1:0] win_reg, win_cur, win_next;
    logic                    overflow_reg, sync_err_reg;
    logic [TAG_WIDTH-1:0]    tag;
    logic                    fifo_full, fifo_empty;
    logic [ACC_WIDTH+TAG_WIDTH-1:0] fifo_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= 1'b0;
            valid_reg <= 1'b0;
            acc_reg   <= '0;
        end else begin
            sync_reg  <= sync_in;
            valid_reg <= valid_in;
            acc_reg   <= acc_in;
        end
    end

    // A sync restarts the window before the coincident word is tagged.
    always_comb begin
        ant_cur  = sync_reg ? '0 : ant_reg;
        tap_cur  = sync_reg ? '0 : tap_reg;
        win_cur  = sync_reg ? '0 : win_reg;
        ant_next = ant_cur;
        tap_next = tap_cur;
        win_next = win_cur;
        if (valid_reg) begin
            if (ant_cur == ANT_MAX) begin
                ant_next = '0;
                if (tap_cur == TAP_MAX) begin
                    tap_next = '0;
                    win_next = win_cur + 1'b1;
                end else begin
                    tap_next = tap_cur + 1'b1;
                end
            end else begin
                ant_next = ant_cur + 1'b1;
            end
        end
        tag = {win_cur, tap_cur, ant_cur, (ant_cur == ANT_MAX) && (tap_cur == TAP_MAX)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ant_reg      <= '0;
            tap_reg      <= '0;
            win_reg      <= '0;
            overflow_reg <= 1'b0;
            sync_err_reg <= 1'b0;
        end else begin
            ant_reg <= ant_next;
            tap_reg <= tap_next;
            win_reg <= win_next;
            if (valid_reg && fifo_full) overflow_reg <= 1'b1;
            if (sync_reg && ((ant_reg != '0) || (tap_reg != '0))) sync_err_reg <= 1'b1;
        end
    end

    xeng_sync_fifo #(
        .WIDTH      (ACC_WIDTH + TAG_WIDTH),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (valid_reg),
        .wr_data  ({acc_reg, tag}),
        .full     (fifo_full),
        .rd_ready (out_ready),
        .rd_data  (fifo_rd_data),
        .empty    (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd_data[TAG_WIDTH +: ACC_WIDTH];
    assign out_last  = fifo_rd_data[TAG_LAST_POS];
    assign out_ant   = fifo_rd_data[TAG_ANT_LSB +: ANT_BITS];
    assign out_tap   = fifo_rd_data[TAP_LSB +: TAP_BITS];
    assign out_win   = fifo_rd_data[WIN_LSB +: WIN_CTR_BITS];
    assign overflow  = overflow_reg;
    assign sync_err  = sync_err_reg;

endmodule

// File: tb/tb_xeng_acc_unloader.sv
// Bench for xeng_acc_unloader: random words checked against a queue model
// that tags by word position since the last sync.
module tb_xeng_acc_unloader;
    localparam int ACC_W = 128, ANT_B = 3, TAP_B = 3, WIN_B = 16;
    localparam int NA = 8, NT = 5, WIN_WORDS = NA * NT, CAP = 33;

    typedef struct packed {
        logic [ACC_W-1:0] d;
        logic [WIN_B-1:0] win;
        logic [TAP_B-1:0] tap;
        logic [ANT_B-1:0] ant;
        logic             last;
    } ent_t;

    logic clk = 1'b0, rst = 1'b0, sync_in = 1'b0, valid_in = 1'b0, out_ready = 1'b0;
    logic [ACC_W-1:0] acc_in = '0;
    logic [ACC_W-1:0] out_data;
    logic [ANT_B-1:0] out_ant;
    logic [TAP_B-1:0] out_tap;
    logic [WIN_B-1:0] out_win;
    logic out_last, out_valid, overflow, sync_err;

    int total = 0, bad = 0;
    ent_t q[$], exp_out[$], got[$];
    logic pend_v = 1'b0, pend_s = 1'b0, exp_ovf = 1'b0, exp_serr = 1'b0;
    logic [ACC_W-1:0] pend_d = '0;
    int pos = 0;

    always #5 clk = ~clk;

    xeng_acc_unloader #(
        .SERIAL_ACC_LEN_BITS(7), .P_FACTOR_BITS(0), .BITWIDTH(4),
        .N_ANTS(NA), .FIFO_DEPTH_BITS(5), .WIN_CTR_BITS(WIN_B)
    ) dut (
        .clk(clk), .rst(rst), .sync_in(sync_in), .acc_in(acc_in), .valid_in(valid_in),
        .out_data(out_data), .out_ant(out_ant), .out_tap(out_tap), .out_win(out_win),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .sync_err(sync_err)
    );

    function automatic ent_t make_ent(input logic [ACC_W-1:0] d, input int p);
        ent_t e;
        int a, t;
        a = p % NA;
        t = (p / NA) % NT;
        e.d    = d;
        e.ant  = ANT_B'(a);
        e.tap  = TAP_B'(t);
        e.win  = WIN_B'(p / WIN_WORDS);
        e.last = (a == NA - 1) && (t == NT - 1);
        return e;
    endfunction

    // Reference: words land in storage one cycle after the port; capacity 33.
    always @(posedge clk) begin : model
        ent_t e;
        logic is_full;
        if (rst) begin
            q.delete();
            pend_v = 1'b0; pend_s = 1'b0; pos = 0;
            exp_ovf = 1'b0; exp_serr = 1'b0;
        end else begin
            is_full = (q.size() == CAP);
            e = '0;
            if (pend_s) begin
                if (pos % WIN_WORDS != 0) exp_serr = 1'b1;
                pos = 0;
            end
            if (pend_v) begin
                e = make_ent(pend_d, pos);
                pos++;
                if (is_full) exp_ovf = 1'b1;
            end
            if (q.size() > 0 && out_ready) exp_out.push_back(q.pop_front());
            if (pend_v && !is_full) q.push_back(e);
            pend_v = valid_in; pend_s = sync_in; pend_d = acc_in;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got.push_back({out_data, out_win, out_tap, out_ant, out_last});
            $display("xfer win=%0d tap=%0d ant=%0d last=%0d data=%h",
                     out_win, out_tap, out_ant, out_last, out_data[31:0]);
        end
    end

    task automatic cyc(input logic s, input logic v);
        sync_in  = s;
        valid_in = v;
        acc_in   = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        cyc(1'b0, 1'b1);
        rst = 1'b0;
        sync_in = 1'b0;
        valid_in = 1'b0;
        got.delete();
        exp_out.delete();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (40) cyc(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) cyc(1'b1, 1'b1);
        rst = 1'b0; sync_in = 1'b0; valid_in = 1'b0;
        total++;
        if ({out_valid, out_last, overflow, sync_err} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {out_valid, out_last, overflow, sync_err});
        end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        total++;
        if ({out_win, out_tap, out_ant} !== '0) begin
            bad++; $display("FAIL reset_tag got=%h want=0", {out_win, out_tap, out_ant});
        end
        got.delete(); exp_out.delete();
    endtask

    task automatic test_nominal();
        logic [ACC_W-1:0] first_d;
        do_reset();
        out_ready = 1'b1;
        cyc(1'b1, 1'b1);
        first_d = acc_in;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL nominal_early got=%b want=0", out_valid); end
        cyc(1'b0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== first_d || {out_win, out_tap, out_ant} !== '0) begin
            bad++; $display("FAIL nominal_latency valid=%b data=%h want=%h", out_valid, out_data, first_d);
        end
        repeat (78) cyc(1'b0, 1'b1);
        drain();
        total++;
        if (got.size() != 80 || exp_out.size() != 80) begin
            bad++; $display("FAIL nominal_count got=%0d model=%0d want=80", got.size(), exp_out.size());
        end
        for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
            total++;
            if (got[i] !== exp_out[i]) begin bad++; $display("FAIL nominal_word%0d got=%h want=%h", i, got[i], exp_out[i]); end
        end
        if (got.size() >= 80) begin
            total++;
            if (got[38].last !== 1'b0 || got[39].last !== 1'b1 || got[79].last !== 1'b1) begin
                bad++; $display("FAIL nominal_last got=%b%b%b want=011", got[38].last, got[39].last, got[79].last);
            end
            total++;
            if (got[40].win !== 16'd1 || got[40].tap !== 3'd0 || got[40].ant !== 3'd0) begin
                bad++; $display("FAIL nominal_win1 got=%0d/%0d/%0d want=1/0/0", got[40].win, got[40].tap, got[40].ant);
            end
        end
    endtask

    task automatic test_sync_aligned();
        do_reset();
        out_ready = 1'b1;
        repeat (40) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1);
        drain();
        total++;
        if (sync_err !== 1'b0) begin bad++; $display("FAIL aligned_err got=%b want=0", sync_err); end
        total++;
        if (got.size() != 44 || got.size() != exp_out.size()) begin
            bad++; $display("FAIL aligned_count got=%0d model=%0d want=44", got.size(), exp_out.size());
        end else begin
            total++;
            if ({got[40].win, got[40].tap, got[40].ant} !== '0 || got[41].ant !== 3'd1) begin
                bad++; $display("FAIL aligned_tag got=%0d/%0d/%0d want=0/0/0", got[40].win, got[40].tap, got[40].ant);
            end
            for (int i = 0; i < 44; i++) begin
                total++;
                if (got[i] !== exp_out[i]) begin bad++; $display("FAIL aligned_word%0d got=%h want=%h", i, got[i], exp_out[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [ACC_W+WIN_B+TAP_B+ANT_B:0] snap;
        do_reset();
        out_ready = 1'b1;
        cyc(1'b1, 1'b1);
        repeat (4) cyc(1'b0, 1'b1);
        out_ready = 1'b0;
        snap = {out_data, out_win, out_tap, out_ant, out_last};
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1);
            total++;
            if (out_valid !== 1'b1 || {out_data, out_win, out_tap, out_ant, out_last} !== snap) begin
                bad++; $display("FAIL bp_hold%0d valid=%b got=%h want=%h", i, out_valid,
                                {out_data, out_win, out_tap, out_ant, out_last}, snap);
            end
        end
        out_ready = 1'b1;
        repeat (15) cyc(1'b0, 1'b1);
        drain();
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL bp_overflow got=%b want=0", overflow); end
        total++;
        if (got.size() != 40 || exp_out.size() != 40) begin
            bad++; $display("FAIL bp_count got=%0d model=%0d want=40", got.size(), exp_out.size());
        end
        for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
            total++;
            if (got[i] !== exp_out[i]) begin bad++; $display("FAIL bp_word%0d got=%h want=%h", i, got[i], exp_out[i]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            cyc(i == 1, 1'b1);
            total++;
            if (overflow !== 1'(i >= 35)) begin
                bad++; $display("FAIL ovf_flag_w%0d got=%b want=%b", i, overflow, 1'(i >= 35));
            end
        end
        cyc(1'b0, 1'b0);
        drain();
        cyc(1'b0, 1'b1);
        drain();
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
        total++;
        if (got.size() != 34 || exp_out.size() != 34) begin
            bad++; $display("FAIL ovf_count got=%0d model=%0d want=34", got.size(), exp_out.size());
        end else begin
            total++;
            if (got[32].tap !== 3'd4 || got[32].ant !== 3'd0 || got[32].win !== 16'd0) begin
                bad++; $display("FAIL ovf_w33 got=%0d/%0d/%0d want=0/4/0", got[32].win, got[32].tap, got[32].ant);
            end
            total++;
            if (got[33].win !== 16'd1 || got[33].tap !== 3'd0 || got[33].ant !== 3'd0) begin
                bad++; $display("FAIL ovf_next got=%0d/%0d/%0d want=1/0/0", got[33].win, got[33].tap, got[33].ant);
            end
            for (int i = 0; i < 34; i++) begin
                total++;
                if (got[i] !== exp_out[i]) begin bad++; $display("FAIL ovf_word%0d got=%h want=%h", i, got[i], exp_out[i]); end
            end
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        out_ready = 1'b1;
        cyc(1'b1, 1'b1);
        repeat (11) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        total++;
        if (sync_err !== 1'b0) begin bad++; $display("FAIL mis_early got=%b want=0", sync_err); end
        cyc(1'b0, 1'b1);
        total++;
        if (sync_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b want=1", sync_err); end
        repeat (5) cyc(1'b0, 1'b1);
        drain();
        total++;
        if (got.size() != 19 || exp_out.size() != 19) begin
            bad++; $display("FAIL mis_count got=%0d model=%0d want=19", got.size(), exp_out.size());
        end else begin
            total++;
            if (got[11].ant !== 3'd3 || got[11].tap !== 3'd1 || {got[12].win, got[12].tap, got[12].ant} !== '0
                || got[13].ant !== 3'd1) begin
                bad++; $display("FAIL mis_tag got=%0d/%0d/%0d want=0/0/0", got[12].win, got[12].tap, got[12].ant);
            end
            for (int i = 0; i < 19; i++) begin
                total++;
                if (got[i] !== exp_out[i]) begin bad++; $display("FAIL mis_word%0d got=%h want=%h", i, got[i], exp_out[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [ACC_W-1:0] d;
        do_reset();
        out_ready = 1'b0;
        cyc(1'b1, 1'b1);
        repeat (4) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        repeat (4) cyc(1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || sync_err !== 1'b1) begin
            bad++; $display("FAIL rmid_pre valid=%b sync_err=%b want=1 1", out_valid, sync_err);
        end
        rst = 1'b1;
        cyc(1'b0, 1'b1);
        rst = 1'b0;
        total++;
        if ({out_valid, out_last, overflow, sync_err} !== 4'b0 || out_data !== '0) begin
            bad++; $display("FAIL rmid_clear got=%b data=%h want=0000", {out_valid, out_last, overflow, sync_err}, out_data);
        end
        got.delete(); exp_out.delete();
        out_ready = 1'b1;
        cyc(1'b0, 1'b1);
        d = acc_in;
        drain();
        total++;
        if (got.size() != 1) begin
            bad++; $display("FAIL rmid_count got=%0d want=1", got.size());
        end else begin
            total++;
            if (got[0].d !== d || {got[0].win, got[0].tap, got[0].ant, got[0].last} !== '0) begin
                bad++; $display("FAIL rmid_word got=%h want=%h tag 0", got[0], d);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            out_ready = ($urandom_range(0, 99) < 55);
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 99) < 75);
        end
        drain();
        total++;
        if (got.size() != exp_out.size()) begin
            bad++; $display("FAIL rand_count got=%0d want=%0d", got.size(), exp_out.size());
        end
        for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
            total++;
            if (got[i] !== exp_out[i]) begin bad++; $display("FAIL rand_word%0d got=%h want=%h", i, got[i], exp_out[i]); end
        end
        total++;
        if (overflow !== exp_ovf || sync_err !== exp_serr) begin
            bad++; $display("FAIL rand_flags got=%b%b want=%b%b", overflow, sync_err, exp_ovf, exp_serr);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_sync_aligned();
        test_backpressure();
        test_overflow();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xeng_acc_unloader.md
# xeng_acc_unloader

Collects accumulated baseline words from the last `baseline_tap` in the X-engine chain and tags each word with its tap and antenna index and a window count. Tagged words are buffered in a small FIFO and presented on a ready/valid stream for the packetiser or the vector-accumulator stage. It is the receiving end of the chain's `acc_out`/`valid_out`/`sync_out` interface. It flags buffer overflow and sync misalignment.

## Interface
Parameters:
- SERIAL_ACC_LEN_BITS, 7, log2 serial accumulation length; must match the tap chain
- P_FACTOR_BITS, 0, log2 parallel samples; must match the tap chain
- BITWIDTH, 4, bits per real/imag sample part
- N_ANTS, 8, dual-pol antennas; power of two, ≥2
- FIFO_DEPTH_BITS, 5, log2 FIFO entries
- WIN_CTR_BITS, 16, width of the window counter
- Derived localparams:
  - ACC_WIDTH = 4*2*((2*BITWIDTH+1)+P_FACTOR_BITS+SERIAL_ACC_LEN_BITS), which is 128 at defaults
  - N_TAPS = N_ANTS/2+1
  - ANT_BITS = log2(N_ANTS)
  - TAP_BITS = log2ceil(N_TAPS)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- sync_in  in  1  window alignment pulse from the chain's sync_out
- acc_in  in  ACC_WIDTH  accumulated word (4 Stokes, complex)
- valid_in  in  1  acc_in qualifier
- out_data  out  ACC_WIDTH  buffered accumulated word, unmodified
- out_ant  out  ANT_BITS  antenna index of the word
- out_tap  out  TAP_BITS  tap index of the word
- out_win  out  WIN_CTR_BITS  window count of the word
- out_last  out  1  final word of a window
- out_valid  out  1  output stream valid
- out_ready  in  1  downstream ready
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- sync_err  out  1  sticky: sync_in arrived while the counters were not at window start

## Operation
- Input stage registers sync_in, acc_in and valid_in (1 cycle).
- Index counters advance on each registered valid word:
  - ant_idx counts 0..N_ANTS-1 and wraps.
  - On ant_idx wrap, tap_idx counts 0..N_TAPS-1 and wraps.
  - On tap_idx wrap, win_ctr increments. win_ctr wraps at 2^WIN_CTR_BITS.
- A tag is formed as {win_ctr, tap_idx, ant_idx, last}. last = (ant_idx==N_ANTS-1 && tap_idx==N_TAPS-1).
- The tag and word are written to the FIFO as one entry.
- Registered sync_in clears ant_idx, tap_idx and win_ctr to 0.
  - If it coincides with a valid word, that word is tagged ant 0, tap 0, win 0, and the counters then advance normally.
  - If sync arrives while (ant_idx,tap_idx)≠(0,0), sync_err is set.
- FIFO full when a valid word arrives:
  - The word is dropped and overflow is set.
  - The counters still advance, so later tags stay correct.
  - Full is evaluated before that cycle's read; a simultaneous pop does not rescue the write.
- Output handshake:
  - An entry transfers when out_valid && out_ready.
  - out_data, out_ant, out_tap, out_win and out_last hold stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
- Sticky flags clear only on rst.
- rst (including mid-stream):
  - flushes the FIFO
  - zeroes the counters
  - sets all outputs to 0: out_valid=0, out_last=0, overflow=0, sync_err=0, and all data and tag outputs 0

## Timing
- Latency: valid_in at cycle t with an empty FIFO and out_ready=1 gives out_valid at t+2 with that word.
- Throughput: one word per cycle sustained while out_ready=1.
- FIFO holds 2^FIFO_DEPTH_BITS entries, plus the output register.
- Write at full drops the word; read at empty does nothing.
- Simultaneous push and pop at non-full, non-empty leaves the occupancy unchanged.
- overflow and sync_err assert the cycle after the offending registered input, i.e. t+2 from the port.
- During the rst cycle, inputs are ignored. The first word accepted is the one presented the cycle after rst deasserts.

## Structure
- Shared package `xeng_pkg`:
  - ACC_WIDTH computation
  - N_TAPS, ANT_BITS and TAP_BITS functions (the log2/log2ceil helpers)
  - tag field ordering constants
- One sub-module, `xeng_sync_fifo`: parameterised width and depth, synchronous reset, registered first-word-fall-through output, full/empty flags.
- The top level holds the input register, the index/window counters, the sync checker and the sticky flags.

## Test plan
- Nominal window: sync then 40 consecutive valid words (N_ANTS=8, 5 taps), out_ready=1.
  - Outputs carry ant 0..7 repeating, tap 0..4, win 0.
  - out_last only on word 40.
  - Next window gives win=1.
  - First output is 2 cycles after the first input.
- Backpressure: hold out_ready=0 for 20 cycles during a window.
  - Output is held stable.
  - No loss until 33 entries are buffered.
  - After release, the words drain in order with correct tags.
- Overflow: out_ready=0 with 40 words input.
  - Words 34..40 are dropped and overflow=1.
  - The next window's first word is still tagged ant 0, tap 0, win 1.
- Misaligned sync: sync at word 13 of a window.
  - sync_err=1.
  - That word is tagged ant 0, tap 0, win 0.
- Sync coincident with valid at window start: no sync_err, and the word is tagged (0,0,0).
- Reset mid-window with 10 entries buffered.
  - Next cycle out_valid=0 and the flags are clear.
  - The following input word is tagged ant 0, tap 0, win 0.
